// File: rtl/exu_muldiv_if.sv
// exu_muldiv_if: request/response handshake bundle for the iterative multiply/divide unit.
interface exu_muldiv_if #(
    parameter int XLEN = 32,
    parameter int FUNC_WIDTH = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FUNC_WIDTH-1:0] in_func;
    logic [XLEN-1:0]       in_a;
    logic [XLEN-1:0]       in_b;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_result;
    modport master (
        output in_valid, in_func, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_result
    );
    modport slave (
        input  in_valid, in_func, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/exu_muldiv.sv
// exu_muldiv: one-bit-per-cycle multiply (shift-add) and restoring divide on operand magnitudes,
// with signs re-applied at the end; divide-by-zero and signed overflow finish in one cycle.
module exu_muldiv #(
    parameter int XLEN = 32,
    parameter int FUNC_WIDTH = 3
) (
    input logic        clk,
    input logic        rst,
    exu_muldiv_if.slave io
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(XLEN);
    state_t state, state_n;
    logic [2:0] op, f_op;
    logic neg, f_neg, sa, sb, sgn_a, sgn_b, by_zero, ovf, accept, last;
    logic [XLEN-1:0] mc, hi, lo, res, ma, mb, sp_res, hi_n, lo_n, fin;
    logic [XLEN:0] sum, shl, diff;
    logic [2*XLEN-1:0] prod, sprod;
    logic [CW-1:0] cnt;
    // Request decode: codes beyond the eight defined ops run as MUL.
    always_comb begin
        f_op = |(io.in_func >> 3) ? 3'd0 : io.in_func[2:0];
        sa = io.in_a[XLEN-1];
        sb = io.in_b[XLEN-1];
        sgn_a = f_op == 3'd1 || f_op == 3'd2 || f_op == 3'd4 || f_op == 3'd6;
        sgn_b = f_op == 3'd1 || f_op == 3'd4 || f_op == 3'd6;
        ma = sgn_a && sa ? -io.in_a : io.in_a;
        mb = sgn_b && sb ? -io.in_b : io.in_b;
        f_neg = (sgn_a & sa) ^ (sgn_b & sb & (f_op != 3'd6));
        by_zero = f_op[2] && io.in_b == '0;
        ovf = f_op[2] && !f_op[0] && io.in_a == {1'b1, {(XLEN-1){1'b0}}} && io.in_b == '1;
        sp_res = by_zero ? (f_op[1] ? io.in_a : '1) : (f_op[1] ? '0 : io.in_a);
        accept = state == IDLE && io.in_valid;
        last = cnt == CW'(XLEN - 1);
    end
    // One iteration step; hi/lo hold product high/low or remainder/quotient.
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
        shl = {hi, lo[XLEN-1]};
        diff = shl - {1'b0, mc};
        hi_n = op[2] ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
        lo_n = op[2] ? {lo[XLEN-2:0], !diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
        prod = {hi_n, lo_n};
        sprod = neg ? -prod : prod;
        fin = op[2] ? (op[1] ? (neg ? -hi_n : hi_n) : (neg ? -lo_n : lo_n))
                    : (op == 3'd0 ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN]);
    end
    always_comb begin
        state_n = io.flush ? IDLE
                : state == IDLE ? (io.in_valid ? ((by_zero || ovf) ? DONE : BUSY) : IDLE)
                : state == BUSY ? (last ? DONE : BUSY)
                : (io.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op    <= '0;
            neg   <= 1'b0;
            mc    <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= state_n;
            if (io.flush) begin
                res <= '0;
            end else if (accept) begin
                op  <= f_op;
                neg <= f_neg;
                mc  <= f_op[2] ? mb : ma;
                lo  <= f_op[2] ? ma : mb;
                hi  <= '0;
                cnt <= '0;
                res <= sp_res;
            end else if (state == BUSY) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + 1'b1;
                if (last) res <= fin;
            end
        end
    end
    assign io.in_ready   = state == IDLE;
    assign io.out_valid  = state == DONE;
    assign io.out_result = state == DONE ? res : '0;
endmodule

// File: doc/exu_muldiv.md
EXU_MULDIV -- requirements
Module: exu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; legal values 8..64, even.
REQ-002 Parameter FUNC_WIDTH, default 3, width of op code.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 in_func  input  FUNC_WIDTH  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 in_a  input  XLEN  operand a (rs1).
REQ-009 in_b  input  XLEN  operand b (rs2).
REQ-010 flush  input  1  abort any in-flight op.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_result  output  XLEN  result.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept = in_valid & in_ready at a rising edge; operands and func SHALL be latched; later input changes have no effect.
REQ-016 Accept with a normal op SHALL move IDLE->BUSY; BUSY SHALL iterate exactly XLEN cycles (one bit per cycle: shift-add multiply, restoring divide on magnitudes), then move to DONE.
REQ-017 Normal-op latency: out_valid SHALL rise XLEN+1 cycles after the accept edge.
REQ-018 Special divide cases SHALL skip BUSY, going IDLE->DONE on the accept edge (out_valid one cycle after accept):
  - divide by zero: DIV/DIVU -> all ones; REM/REMU -> in_a.
  - signed overflow (in_a = most-negative, in_b = -1): DIV -> in_a; REM -> 0.
REQ-019 MUL SHALL return low XLEN bits of the 2*XLEN product; MULH signed x signed high half; MULHSU signed a x unsigned b high half; MULHU unsigned high half.
REQ-020 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign; DIVU/REMU unsigned.
REQ-021 DONE SHALL hold out_valid and a stable out_result until out_valid & out_ready, then return to IDLE; no new request SHALL be accepted in that same cycle.
REQ-022 flush SHALL have priority over all events: at the edge where flush=1, state SHALL go to IDLE, any in-flight or held result SHALL be discarded, and a same-cycle in_valid SHALL NOT be accepted.
REQ-023 Unused func codes (FUNC_WIDTH > 3) SHALL complete as MUL.
REQ-024 out_result SHALL be 0 whenever out_valid = 0.

Reset
REQ-025 rst low SHALL asynchronously force state IDLE, in_ready 1, out_valid 0, out_result 0, all datapath registers 0.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL discard the operation; after rst release the first accepted request SHALL behave as from a cold start.

Verification
REQ-027 XLEN=32, MUL a=0xFFFFFFFF b=0xFFFFFFFF, out_ready=1 -> out_valid at accept+33 cycles, result 0x00000001; same operands MULHU -> 0xFFFFFFFE; MULH -> 0x00000000.
REQ-028 DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100 b=7 -> 14; REMU -> 2.
REQ-029 DIV a=5 b=0 -> 0xFFFFFFFF after 1 cycle; REMU a=5 b=0 -> 5; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000 after 1 cycle; REM same operands -> 0.
REQ-030 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and result stable, in_ready 0 throughout; out_ready=1 -> IDLE next cycle, in_ready 1.
REQ-031 flush at cycle 10 of BUSY with in_valid=1 -> no out_valid, IDLE next cycle, request not accepted; next request completes with correct result.
REQ-032 rst pulse low mid-BUSY -> outputs zero immediately (asynchronously, without waiting for clk); XLEN=8 run of MULHSU a=0x80 b=0xFF -> 0x80 at accept+9.
